// File: rtl/lse_mult_pipe.sv
// lse_mult_pipe: two-stage log-space multiplier (saturating add), full-width or packed sub-word lanes.
// Define LSE_MULT_SAT_STICKY_EN to add per-lane sticky saturation flags (i_sat_clr / o_sat_sticky).
module lse_mult_pipe #(
  parameter int P_WIDTH     = 24,
  parameter int P_LANES     = 4,
  parameter int P_SUB_WIDTH = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [P_WIDTH-1:0] i_operand_a,
  input  logic [P_WIDTH-1:0] i_operand_b,
  input  logic [1:0]         i_pe_mode,
`ifdef LSE_MULT_SAT_STICKY_EN
  input  logic               i_sat_clr,
  output logic [P_LANES-1:0] o_sat_sticky,
`endif
  output logic               o_valid,
  input  logic               i_ready,
  output logic [P_WIDTH-1:0] o_product,
  output logic [1:0]         o_mode
);

  localparam logic [P_WIDTH-1:0]        FULL_NEG_INF = {1'b1, {(P_WIDTH-1){1'b0}}};
  localparam logic [P_WIDTH-1:0]        FULL_MAX     = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [P_WIDTH-1:0]        FULL_MIN_FIN = {1'b1, {(P_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [P_WIDTH:0]   FULL_MAX_EXT = {2'b00, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH:0]   FULL_MIN_EXT = {2'b11, {(P_WIDTH-2){1'b0}}, 1'b1};

  localparam logic [P_SUB_WIDTH-1:0]      SUB_NEG_INF = {1'b1, {(P_SUB_WIDTH-1){1'b0}}};
  localparam logic [P_SUB_WIDTH-1:0]      SUB_MAX     = {1'b0, {(P_SUB_WIDTH-1){1'b1}}};
  localparam logic [P_SUB_WIDTH-1:0]      SUB_MIN_FIN = {1'b1, {(P_SUB_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [P_SUB_WIDTH:0] SUB_MAX_EXT = {2'b00, {(P_SUB_WIDTH-1){1'b1}}};
  localparam logic signed [P_SUB_WIDTH:0] SUB_MIN_EXT = {2'b11, {(P_SUB_WIDTH-2){1'b0}}, 1'b1};

  logic               en;
  logic               s1_valid;
  logic [P_WIDTH-1:0] s1_a;
  logic [P_WIDTH-1:0] s1_b;
  logic [1:0]         s1_mode;

  // A single enable stalls every stage together; downstream backpressure reaches o_ready combinationally.
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 2'd0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_a     <= i_operand_a;
      s1_b     <= i_operand_b;
      s1_mode  <= i_pe_mode;
    end
  end

  logic signed [P_WIDTH:0] full_sum;
  logic                    full_ninf;
  logic                    full_ovf;
  logic                    full_unf;
  logic [P_WIDTH-1:0]      full_res;

  assign full_sum  = $signed({s1_a[P_WIDTH-1], s1_a}) + $signed({s1_b[P_WIDTH-1], s1_b});
  assign full_ninf = (s1_a == FULL_NEG_INF) | (s1_b == FULL_NEG_INF);
  assign full_ovf  = full_sum > FULL_MAX_EXT;
  assign full_unf  = full_sum < FULL_MIN_EXT;

  always_comb begin
    full_res = full_sum[P_WIDTH-1:0];
    if (full_ninf)     full_res = FULL_NEG_INF;
    else if (full_ovf) full_res = FULL_MAX;
    else if (full_unf) full_res = FULL_MIN_FIN;
  end

  logic [P_WIDTH-1:0] packed_res;
`ifdef LSE_MULT_SAT_STICKY_EN
  logic [P_LANES-1:0] packed_sat;
`endif

  // Each lane sums at one extra bit so nothing carries into its neighbour.
  for (genvar k = 0; k < P_LANES; k++) begin : g_lane
    logic [P_SUB_WIDTH-1:0]      la;
    logic [P_SUB_WIDTH-1:0]      lb;
    logic signed [P_SUB_WIDTH:0] lsum;
    logic                        ninf;
    logic                        ovf;
    logic                        unf;

    assign la   = s1_a[k*P_SUB_WIDTH +: P_SUB_WIDTH];
    assign lb   = s1_b[k*P_SUB_WIDTH +: P_SUB_WIDTH];
    assign lsum = $signed({la[P_SUB_WIDTH-1], la}) + $signed({lb[P_SUB_WIDTH-1], lb});
    assign ninf = (la == SUB_NEG_INF) | (lb == SUB_NEG_INF);
    assign ovf  = lsum > SUB_MAX_EXT;
    assign unf  = lsum < SUB_MIN_EXT;

    assign packed_res[k*P_SUB_WIDTH +: P_SUB_WIDTH] =
      ninf ? SUB_NEG_INF : ovf ? SUB_MAX : unf ? SUB_MIN_FIN : lsum[P_SUB_WIDTH-1:0];
`ifdef LSE_MULT_SAT_STICKY_EN
    assign packed_sat[k] = ~ninf & (ovf | unf);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_product <= '0;
      o_mode    <= 2'd0;
    end else if (en) begin
      o_valid   <= s1_valid;
      o_product <= (s1_mode == 2'd0) ? full_res : packed_res;
      o_mode    <= s1_mode;
    end
  end

`ifdef LSE_MULT_SAT_STICKY_EN
  logic               full_sat;
  logic [P_LANES-1:0] s2_sat;
  logic [P_LANES-1:0] sat_set;

  assign full_sat = ~full_ninf & (full_ovf | full_unf);
  assign sat_set  = (o_valid & i_ready) ? s2_sat : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_sat <= '0;
    end else if (en) begin
      s2_sat <= (s1_mode == 2'd0) ? {{(P_LANES-1){1'b0}}, full_sat} : packed_sat;
    end
  end

  // Flags only record results that actually leave the pipe; a coincident clear loses to a new set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sat_sticky <= '0;
    end else if (i_sat_clr) begin
      o_sat_sticky <= sat_set;
    end else begin
      o_sat_sticky <= o_sat_sticky | sat_set;
    end
  end
`endif

endmodule
